// File: rtl/garage_door_pkg.sv
// Shared types for the second-generation garage door controller.
package garage_door_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MV_UP = 3'd1,
        ST_MV_DN = 3'd2,
        ST_DEAD  = 3'd3,
        ST_FAULT = 3'd4
    } gdc_state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/gdc_cycle_timer.sv
// Clearable cycle counter with a terminal-count compare against a run-time limit.
module gdc_cycle_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/garage_door_ctrl_v2.sv
// Garage door motor controller: edge-triggered activate, stop/reverse,
// obstruction auto-reversal through a dead time, and a run timeout fault.
module garage_door_ctrl_v2
    import garage_door_pkg::*;
#(
    parameter int unsigned RUN_TIMEOUT = 1000,
    parameter int unsigned DEAD_TIME   = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic Activate,
    input  logic Up_max,
    input  logic Dn_max,
    input  logic Obstruct,
    input  logic Clear_fault,
    output logic Up_M,
    output logic Dn_M,
    output logic Fault,
    output logic Busy
);

    localparam logic [CNT_W-1:0] RUN_TERM  = CNT_W'(RUN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DEAD_TERM = CNT_W'(DEAD_TIME - 1);

    gdc_state_e       state_q, state_d;
    logic             act_d_q;
    logic             last_dir_q;
    logic             up_m_q, dn_m_q, fault_q, busy_q;
    logic             act;
    logic             busy_st;
    logic             tmr_clr, tmr_tc;
    logic [CNT_W-1:0] tmr_term, cnt;

    assign act      = Activate & ~act_d_q;
    assign busy_st  = (state_q == ST_MV_UP) || (state_q == ST_MV_DN) || (state_q == ST_DEAD);
    assign tmr_term = (state_q == ST_DEAD) ? DEAD_TERM : RUN_TERM;
    assign tmr_clr  = RST || (state_d != state_q);

    // One counter serves both run and dead timing; only the compare target differs.
    gdc_cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i   (CLK),
        .clr_i   (tmr_clr),
        .en_i    (busy_st),
        .term_i  (tmr_term),
        .count_o (cnt),
        .tc_o    (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (act) begin
                    if (Up_max && Dn_max)      state_d = ST_FAULT;
                    else if (Dn_max)           state_d = ST_MV_UP;
                    else if (Up_max)           state_d = ST_MV_DN;
                    else if (last_dir_q == DIR_UP) state_d = ST_MV_DN;
                    else                       state_d = ST_MV_UP;
                end
            end
            ST_MV_UP: begin
                if (Up_max && Dn_max)          state_d = ST_FAULT;
                else if (Up_max)               state_d = ST_IDLE;
                else if (tmr_tc)               state_d = ST_FAULT;
                else if (act)                  state_d = ST_IDLE;
            end
            ST_MV_DN: begin
                if (Up_max && Dn_max)          state_d = ST_FAULT;
                else if (Dn_max)               state_d = ST_IDLE;
                else if (Obstruct)             state_d = ST_DEAD;
                else if (tmr_tc)               state_d = ST_FAULT;
                else if (act)                  state_d = ST_IDLE;
            end
            ST_DEAD: begin
                if (Up_max)                    state_d = ST_IDLE;
                else if (tmr_tc)               state_d = ST_MV_UP;
            end
            ST_FAULT: begin
                if (Clear_fault && !(Up_max && Dn_max)) state_d = ST_IDLE;
            end
            default:                           state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            act_d_q    <= 1'b0;
            last_dir_q <= DIR_DN;
            up_m_q     <= 1'b0;
            dn_m_q     <= 1'b0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            act_d_q <= Activate;
            if (state_d != state_q) begin
                if (state_d == ST_MV_UP)      last_dir_q <= DIR_UP;
                else if (state_d == ST_MV_DN) last_dir_q <= DIR_DN;
            end
            up_m_q  <= (state_d == ST_MV_UP);
            dn_m_q  <= (state_d == ST_MV_DN);
            fault_q <= (state_d == ST_FAULT);
            busy_q  <= (state_d == ST_MV_UP) || (state_d == ST_MV_DN) || (state_d == ST_DEAD);
        end
    end

    a_cnt_bound: assert property (@(posedge CLK) disable iff (RST) busy_st |-> (cnt <= tmr_term));

    assign Up_M  = up_m_q;
    assign Dn_M  = dn_m_q;
    assign Fault = fault_q;
    assign Busy  = busy_q;

endmodule

// File: tb/tb_garage_door_ctrl_v2.sv
// Scoreboard bench for garage_door_ctrl_v2 with RUN_TIMEOUT=20, DEAD_TIME=4.
module tb_garage_door_ctrl_v2;

    // Expected output vectors: {Up_M, Dn_M, Fault, Busy}
    localparam logic [3:0] O_IDLE = 4'b0000;
    localparam logic [3:0] O_UP   = 4'b1001;
    localparam logic [3:0] O_DN   = 4'b0101;
    localparam logic [3:0] O_DEAD = 4'b0001;
    localparam logic [3:0] O_FLT  = 4'b0010;

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } sb_entry_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic Activate = 1'b0;
    logic Up_max = 1'b0;
    logic Dn_max = 1'b0;
    logic Obstruct = 1'b0;
    logic Clear_fault = 1'b0;
    logic Up_M, Dn_M, Fault, Busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    sb_entry_t   sb_q[$];

    garage_door_ctrl_v2 #(
        .RUN_TIMEOUT (20),
        .DEAD_TIME   (4),
        .CNT_W       (16)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Activate    (Activate),
        .Up_max      (Up_max),
        .Dn_max      (Dn_max),
        .Obstruct    (Obstruct),
        .Clear_fault (Clear_fault),
        .Up_M        (Up_M),
        .Dn_M        (Dn_M),
        .Fault       (Fault),
        .Busy        (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {Up_M,Dn_M,Fault,Busy}=%b expected %b", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic a, input logic up,
                        input logic dn, input logic ob, input logic cf, input logic [3:0] exp);
        sb_entry_t e;
        RST = r; Activate = a; Up_max = up; Dn_max = dn; Obstruct = ob; Clear_fault = cf;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, {Up_M, Dn_M, Fault, Busy}, 4'bxxxx);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, {Up_M, Dn_M, Fault, Busy}, e.exp);
        end
    endtask

    initial begin
        // Reset
        step("reset",      1, 0, 0, 0, 0, 0, O_IDLE);
        step("reset_rel",  0, 0, 0, 1, 0, 0, O_IDLE);

        // Open from closed, reach Up_max after 10 cycles
        step("open_start", 0, 1, 0, 1, 0, 0, O_UP);
        for (int i = 0; i < 9; i++) step("open_run", 0, 0, 0, 0, 0, 0, O_UP);
        step("open_limit", 0, 0, 1, 0, 0, 0, O_IDLE);
        step("open_rest",  0, 0, 1, 0, 0, 0, O_IDLE);

        // Stop mid-travel and reverse
        step("sr_closed",  0, 0, 0, 1, 0, 0, O_IDLE);
        step("sr_open",    0, 1, 0, 1, 0, 0, O_UP);
        for (int i = 0; i < 4; i++) step("sr_run", 0, 0, 0, 0, 0, 0, O_UP);
        step("sr_stop",    0, 1, 0, 0, 0, 0, O_IDLE);
        step("sr_release", 0, 0, 0, 0, 0, 0, O_IDLE);
        step("sr_reverse", 0, 1, 0, 0, 0, 0, O_DN);
        step("sr_closed2", 0, 0, 0, 1, 0, 0, O_IDLE);

        // Obstruction auto-reversal while closing
        step("ob_top",     0, 0, 1, 0, 0, 0, O_IDLE);
        step("ob_close",   0, 1, 1, 0, 0, 0, O_DN);
        for (int i = 0; i < 4; i++) step("ob_run", 0, 0, 0, 0, 0, 0, O_DN);
        step("ob_hit",     0, 0, 0, 0, 1, 0, O_DEAD);
        step("ob_dead1",   0, 1, 0, 0, 1, 0, O_DEAD);
        step("ob_dead2",   0, 0, 0, 0, 1, 0, O_DEAD);
        step("ob_dead3",   0, 0, 0, 0, 0, 0, O_DEAD);
        step("ob_revup",   0, 0, 0, 0, 1, 0, O_UP);
        step("ob_upobs",   0, 0, 0, 0, 1, 0, O_UP);
        step("ob_top2",    0, 0, 1, 0, 0, 0, O_IDLE);

        // Run timeout: exactly 20 motor-on cycles, then fault
        step("to_closed",  0, 0, 0, 1, 0, 0, O_IDLE);
        step("to_start",   0, 1, 0, 1, 0, 0, O_UP);
        for (int i = 0; i < 19; i++) step("to_run", 0, 0, 0, 0, 0, 0, O_UP);
        step("to_fault",   0, 0, 0, 0, 0, 0, O_FLT);
        step("to_hold",    0, 1, 0, 0, 0, 0, O_FLT);
        step("to_clear",   0, 0, 0, 0, 0, 1, O_IDLE);

        // Both limits with Activate, clear blocked while both remain
        step("bl_idle",    0, 0, 1, 1, 0, 0, O_IDLE);
        step("bl_fault",   0, 1, 1, 1, 0, 0, O_FLT);
        step("bl_noclr",   0, 0, 1, 1, 0, 1, O_FLT);
        step("bl_clear",   0, 0, 1, 0, 0, 1, O_IDLE);

        // Reset mid-travel
        step("rs_top",     0, 0, 1, 0, 0, 0, O_IDLE);
        step("rs_close",   0, 1, 1, 0, 0, 0, O_DN);
        step("rs_run",     0, 0, 0, 0, 0, 0, O_DN);
        step("rs_reset",   1, 0, 0, 0, 0, 0, O_IDLE);
        step("rs_after",   0, 0, 0, 0, 0, 0, O_IDLE);
        step("rs_dirup",   0, 1, 0, 0, 0, 0, O_UP);
        step("rs_stop",    0, 0, 1, 0, 0, 0, O_IDLE);

        // Held Activate: 30 cycles high, exactly one transition caused
        step("hb_top",     0, 0, 1, 0, 0, 0, O_IDLE);
        step("hb_close",   0, 1, 1, 0, 0, 0, O_DN);
        for (int i = 0; i < 4; i++) step("hb_run", 0, 1, 0, 0, 0, 0, O_DN);
        step("hb_closed",  0, 1, 0, 1, 0, 0, O_IDLE);
        for (int i = 0; i < 24; i++) step("hb_held", 0, 1, 0, 1, 0, 0, O_IDLE);
        step("hb_low",     0, 0, 0, 1, 0, 0, O_IDLE);
        step("hb_retrig",  0, 1, 0, 1, 0, 0, O_UP);
        step("hb_end",     0, 0, 1, 0, 0, 0, O_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
